// File: rtl/sblk_act_dispatch_if.sv
// Row-tagged activation stream from the global buffer controller into the dispatcher.
// The tag MSB selects broadcast; the low bits select a single row.
interface sblk_act_dispatch_if #(
    parameter int unsigned WID_ACT = 16,
    parameter int unsigned WID_ROW = 4
);
    logic [2*WID_ACT-1:0] in_data;
    logic [WID_ROW-1:0]   in_row;
    logic                 in_vld;
    logic                 in_rdy;

    modport master (
        output in_data,
        output in_row,
        output in_vld,
        input  in_rdy
    );

    modport slave (
        input  in_data,
        input  in_row,
        input  in_vld,
        output in_rdy
    );
endinterface

// File: rtl/sblk_act_dispatch.sv
// Activation dispatcher: demuxes or broadcasts a tagged word stream into per-row FIFOs and
// delivers each row's words as registered one-cycle pulses under that row's req.
module sblk_act_dispatch #(
    parameter int unsigned N_ROW      = 8,
    parameter int unsigned WID_ACT    = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WID_ROW    = $clog2(N_ROW) + 1
) (
    input  logic                         clk_l,
    input  logic                         rst,
    sblk_act_dispatch_if.slave           in_if,
    output logic [2*WID_ACT*N_ROW-1:0]   act_data_in,
    output logic [N_ROW-1:0]             act_data_in_vld,
    input  logic [N_ROW-1:0]             act_data_in_req,
    input  logic                         flush,
    output logic [N_ROW-1:0]             fifo_empty,
    output logic                         busy,
    output logic                         err_row
);
    localparam int unsigned W  = 2 * WID_ACT;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  mem_q    [N_ROW][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q [N_ROW];
    logic [PW-1:0] rd_ptr_q [N_ROW];
    logic [W-1:0]  data_q   [N_ROW];
    logic [N_ROW-1:0] vld_q;
    logic             err_q;

    logic [N_ROW-1:0]   full, empty, push, pop;
    logic [WID_ROW-2:0] idx;
    logic               bcast, idx_ok, sel_full, accept;

    assign bcast  = in_if.in_row[WID_ROW-1];
    assign idx    = in_if.in_row[WID_ROW-2:0];
    assign idx_ok = 32'(idx) < N_ROW;

    always_comb begin
        full     = '0;
        empty    = '0;
        pop      = '0;
        sel_full = 1'b0;
        for (int unsigned r = 0; r < N_ROW; r++) begin
            empty[r] = (wr_ptr_q[r] == rd_ptr_q[r]);
            full[r]  = (wr_ptr_q[r][PW-1] != rd_ptr_q[r][PW-1]) &&
                       (wr_ptr_q[r][AW-1:0] == rd_ptr_q[r][AW-1:0]);
            pop[r]   = act_data_in_req[r] && !empty[r];
            if (32'(idx) == r) sel_full = full[r];
        end
    end

    // Ready never looks at req: a full FIFO refuses even when it pops this cycle.
    always_comb begin
        in_if.in_rdy = 1'b0;
        if (rst || flush)  in_if.in_rdy = 1'b0;
        else if (bcast)    in_if.in_rdy = ~|full;
        else if (idx_ok)   in_if.in_rdy = !sel_full;
        else               in_if.in_rdy = 1'b1;
    end

    assign accept = in_if.in_vld && in_if.in_rdy;

    always_comb begin
        push = '0;
        for (int unsigned r = 0; r < N_ROW; r++) begin
            push[r] = accept && (bcast || (32'(idx) == r));
        end
    end

    always_ff @(posedge clk_l) begin
        for (int unsigned r = 0; r < N_ROW; r++) begin
            if (push[r]) mem_q[r][wr_ptr_q[r][AW-1:0]] <= in_if.in_data;
        end
    end

    always_ff @(posedge clk_l) begin
        if (rst) begin
            err_q <= 1'b0;
            vld_q <= '0;
            for (int unsigned r = 0; r < N_ROW; r++) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
                data_q[r]   <= '0;
            end
        end else begin
            if (accept && !bcast && !idx_ok) err_q <= 1'b1;
            if (flush) begin
                vld_q <= '0;
                for (int unsigned r = 0; r < N_ROW; r++) begin
                    wr_ptr_q[r] <= '0;
                    rd_ptr_q[r] <= '0;
                    data_q[r]   <= '0;
                end
            end else begin
                for (int unsigned r = 0; r < N_ROW; r++) begin
                    if (push[r]) wr_ptr_q[r] <= wr_ptr_q[r] + PW'(1);
                    if (pop[r]) begin
                        rd_ptr_q[r] <= rd_ptr_q[r] + PW'(1);
                        data_q[r]   <= mem_q[r][rd_ptr_q[r][AW-1:0]];
                        vld_q[r]    <= 1'b1;
                    end else begin
                        vld_q[r]    <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        act_data_in = '0;
        for (int unsigned r = 0; r < N_ROW; r++) begin
            act_data_in[r*W +: W] = data_q[r];
        end
    end

    assign act_data_in_vld = vld_q;
    assign fifo_empty      = empty;
    assign busy            = (~&empty) | (|vld_q);
    assign err_row         = err_q;
endmodule
